cfg_chain_loader: RTL and testbench

- Configuration sequencer for the tile's configuration-flop chain, which daisy-chains through the module1/module2 instance grid.
- Accepts configuration words over a valid/ready stream and serializes them LSB-first onto the chain head.
- After loading, runs a non-destructive read-back pass that recirculates the chain and checks the tail against a shadow copy.
- Sits between the tile-level bitstream feeder and the chain's head/enable/tail pins.

---
 rtl/cfg_chain_pkg.sv | 21 ++
 rtl/cfg_word_serializer.sv | 50 +++++
 rtl/cfg_chain_loader.sv | 174 +++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_chain_pkg.sv
// Purpose: shared types and helpers for the configuration-chain loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cfg_chain_pkg;

    // Controller phases: wait for request, fetch a word, shift it out,
    // recirculate-and-compare, then a single completion cycle.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Number of input words needed to cover the whole chain.
    function automatic int words_needed(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Purpose: holds one configuration word and presents it LSB-first, one bit per advance.
// Latency: head_bit valid the cycle after load; each advance exposes the next bit.
// Backpressure: none internally; the owner decides when to load and advance.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   load        - capture word_in and restart the bit index
//   word_in     - configuration word to serialize
//   advance     - consume the current head bit
//   head_bit    - bit currently presented (word bit idx)
//   last_bit    - head_bit is the final bit of the word
module cfg_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word_in,
    input  logic              advance,
    output logic              head_bit,
    output logic              last_bit
);

    // One extra count value so the index can sit at WORD_W without wrapping.
    localparam int IDX_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;

    // The word is shifted right as bits are consumed, so the head is always
    // bit 0 of the register and no variable-width bit select is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load) begin
            word_q <= word_in;
            idx_q  <= '0;
        end else if (advance) begin
            word_q <= word_q >> 1;
            if (idx_q != IDX_W'(WORD_W)) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign head_bit = word_q[0];
    assign last_bit = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/cfg_chain_loader.sv
// Purpose: loads the tile configuration-flop chain from a word stream, then read-back verifies it.
// Latency: CHAIN_LEN shift + one LOAD cycle per word + CHAIN_LEN verify + 1 done cycle.
// Backpressure: cfg_ready only in LOAD; a stalled feeder holds the chain (ccff_en=0) indefinitely.
//
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   start            - request a load (ignored while busy)
//   cfg_data/_valid  - configuration word stream, bit 0 shifted first
//   cfg_ready        - word accepted this cycle when cfg_valid is also high
//   ccff_head/_en    - serial data and shift enable into the chain
//   ccff_tail        - output of the last chain flop
//   busy, done       - operation in progress / one-cycle completion pulse
//   error            - sticky read-back mismatch, cleared by an accepted start
//   bit_count        - bits shifted in the current phase (saturates at CHAIN_LEN)
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic               error_q, error_d;
    logic [CHAIN_LEN-1:0] shadow_q;

    logic ser_load;
    logic ser_advance;
    logic ser_bit;
    logic ser_last;
    logic shadow_we;
    logic shadow_bit;
    logic count_last;

    cfg_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .word_in  (cfg_data),
        .advance  (ser_advance),
        .head_bit (ser_bit),
        .last_bit (ser_last)
    );

    // The final bit of either phase; the counter never runs past CHAIN_LEN.
    assign count_last = (bit_count_q == CNT_W'(CHAIN_LEN - 1));

    // Shadow bit for the current verify position. bit_count is the same
    // index that wrote it during SHIFT, so tail order matches load order.
    always_comb begin
        shadow_bit = 1'b0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (bit_count_q == CNT_W'(i)) begin
                shadow_bit = shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_count_q <= '0;
            error_q     <= 1'b0;
            shadow_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            error_q     <= error_d;
            for (int i = 0; i < CHAIN_LEN; i++) begin
                if (shadow_we && (bit_count_q == CNT_W'(i))) begin
                    shadow_q[i] <= ccff_head;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        error_d     = error_q;
        cfg_ready   = 1'b0;
        ccff_en     = 1'b0;
        ccff_head   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        shadow_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    error_d     = 1'b0;
                    bit_count_d = '0;
                end
            end

            LOAD: begin
                busy      = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    ser_load = 1'b1;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                busy        = 1'b1;
                ccff_en     = 1'b1;
                ccff_head   = ser_bit;
                shadow_we   = 1'b1;
                ser_advance = 1'b1;
                // Chain full takes priority: leftover high bits of the
                // final word are simply dropped with the serializer state.
                if (count_last) begin
                    state_d     = VERIFY;
                    bit_count_d = '0;
                end else begin
                    bit_count_d = bit_count_q + 1'b1;
                    if (ser_last) begin
                        state_d = LOAD;
                    end
                end
            end

            VERIFY: begin
                busy    = 1'b1;
                ccff_en = 1'b1;
                // Loopback: after CHAIN_LEN shifts every flop is back in place.
                ccff_head = ccff_tail;
                if (ccff_tail != shadow_bit) begin
                    error_d = 1'b1;
                end
                if (count_last) begin
                    state_d     = DONE;
                    bit_count_d = CNT_W'(CHAIN_LEN);
                end else begin
                    bit_count_d = bit_count_q + 1'b1;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign error     = error_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Purpose: directed bench for cfg_chain_loader with a behavioural 10-flop chain and reference model.
// Latency: n/a.
// Backpressure: feeder stalls and held-valid patterns are driven from the stimulus tasks.
module tb_cfg_chain_loader;

    localparam int L  = 10;
    localparam int W  = 4;
    localparam int CW = $clog2(L + 1);
    // i-th shifted bit ends in flop L-1-i: stream 0,1,0,1,1,0,1,0,1,1
    localparam logic [L-1:0] EXP_CHAIN = 10'b01_0110_1011;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] bit_count;

    always #5 clk = ~clk;

    cfg_chain_loader #(
        .CHAIN_LEN (L),
        .WORD_W    (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .ccff_head (ccff_head),
        .ccff_en   (ccff_en),
        .ccff_tail (ccff_tail),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bit_count (bit_count)
    );

    // ---------------- behavioural chain ----------------
    logic [L-1:0] chain;
    logic [L-1:0] snap;
    logic [L-1:0] flip;
    int           shift_cnt = 0;
    bit           arm_corrupt = 1'b0;

    assign ccff_tail = chain[L-1];
    // Optional upset of flop 3 on the last load shift, before read-back.
    assign flip = (arm_corrupt && shift_cnt == L - 1) ? (L'(1) << 3) : '0;

    always @(posedge clk) begin
        if (ccff_en) chain <= {chain[L-2:0], ccff_head} ^ flip;
    end

    always @(posedge clk) begin
        if (start) shift_cnt <= 0;
        else if (ccff_en) shift_cnt <= shift_cnt + 1;
        if (ccff_en && shift_cnt == L - 1) snap <= {chain[L-2:0], ccff_head} ^ flip;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for word, 2 shifting,
    // 3 read-back, 4 completion. Pending bits of the current word sit in a queue.
    int  m_ph = 0;
    bit  m_q[$];
    bit  m_bits[L];
    int  m_n = 0;
    int  m_v = 0;
    int  m_cnt = 0;
    bit  m_err = 1'b0;
    bit  chk_en = 1'b0;
    int  hs_cnt = 0;
    int  done_cnt = 0;

    always @(negedge clk) begin
        logic e_ready, e_en, e_head, e_busy, e_done;
        logic [CW-1:0] e_cnt;
        if (chk_en) begin
            e_ready = (m_ph == 1);
            e_en    = (m_ph == 2) || (m_ph == 3);
            e_head  = (m_ph == 2) ? ((m_q.size() > 0) ? m_q[0] : 1'b0)
                    : (m_ph == 3) ? ccff_tail : 1'b0;
            e_busy  = (m_ph >= 1) && (m_ph <= 3);
            e_done  = (m_ph == 4);
            e_cnt   = m_cnt[CW-1:0];
            check("cycle_outputs",
                  {cfg_ready, ccff_en, ccff_head, busy, done, error, bit_count},
                  {e_ready, e_en, e_head, e_busy, e_done, m_err, e_cnt});
            if (cfg_valid && cfg_ready) hs_cnt++;
            if (done) done_cnt++;

            if (reset) begin
                m_ph = 0; m_err = 1'b0; m_cnt = 0; m_q.delete();
            end else begin
                case (m_ph)
                    0: if (start) begin m_ph = 1; m_err = 1'b0; m_cnt = 0; m_n = 0; end
                    1: if (cfg_valid) begin
                        for (int k = 0; k < W; k++)
                            if (m_n + m_q.size() < L) m_q.push_back(cfg_data[k]);
                        m_ph = 2;
                    end
                    2: begin
                        m_bits[m_n] = m_q.pop_front();
                        m_n++;
                        if (m_n == L) begin
                            m_ph = 3; m_v = 0; m_cnt = 0; m_q.delete();
                        end else begin
                            m_cnt = m_n;
                            if (m_q.size() == 0) m_ph = 1;
                        end
                    end
                    3: begin
                        if (ccff_tail !== m_bits[m_v]) m_err = 1'b1;
                        m_v++;
                        m_cnt = m_v;
                        if (m_v == L) m_ph = 4;
                    end
                    default: m_ph = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full load of three words. stall: idle LOAD cycles before word 2.
    // hold: pulse start during SHIFT and keep cfg_valid high after the last word.
    task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input int stall, input bit hold,
                            output int lat, output logic err_after_start);
        logic [W-1:0] ws[3];
        bit acc;
        int budget;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        err_after_start = error;
        lat = 0;
        budget = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1 && stall > 0) begin
                cfg_valid = 1'b0;
                while (!cfg_ready && budget < 200) begin cyc(); lat++; budget++; end
                repeat (stall) begin
                    check("stall_en_low", ccff_en, 1'b0);
                    cyc(); lat++;
                end
            end
            cfg_valid = 1'b1;
            cfg_data  = ws[i];
            acc = 1'b0;
            while (!acc && budget < 200) begin acc = cfg_ready; cyc(); lat++; budget++; end
            if (i == 1 && hold) begin
                start = 1'b1; cyc(); lat++; start = 1'b0;
            end
        end
        if (hold) cfg_data = '0;
        else cfg_valid = 1'b0;
        while (!done && budget < 200) begin cyc(); lat++; budget++; end
        cfg_valid = 1'b0;
        check("run_within_budget", budget < 200, 1'b1);
        lat = lat + 1;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        int d0;
        int h0;
        int n_en;
        logic eas;

        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (5) cyc();
        check("idle_outputs", {cfg_ready, ccff_en, ccff_head, busy, done, error, bit_count}, '0);

        // Plain load: A, 5, F back to back.
        d0 = done_cnt;
        run_load(4'hA, 4'h5, 4'hF, 0, 1'b0, lat, eas);
        check("t1_latency", lat, 24);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_error", error, 1'b0);
        check("t1_loaded_chain", snap, EXP_CHAIN);
        check("t1_chain_after_verify", chain, EXP_CHAIN);
        check("t1_bit_count_final", bit_count, L);
        check("t1_busy_after", busy, 1'b0);

        // Flop 3 upset before read-back.
        arm_corrupt = 1'b1;
        run_load(4'hA, 4'h5, 4'hF, 0, 1'b0, lat, eas);
        arm_corrupt = 1'b0;
        check("t2_error_set", error, 1'b1);
        cyc();
        check("t2_error_sticky", error, 1'b1);
        check("t2_chain", chain, EXP_CHAIN ^ 10'h008);

        // Feeder stall of 7 cycles before word 2; start clears the error.
        run_load(4'hA, 4'h5, 4'hF, 7, 1'b0, lat, eas);
        check("t3_start_clears_error", eas, 1'b0);
        check("t3_latency", lat, 31);
        check("t3_chain", chain, EXP_CHAIN);
        check("t3_error", error, 1'b0);

        // start during SHIFT and valid held high outside LOAD.
        h0 = hs_cnt;
        d0 = done_cnt;
        run_load(4'hA, 4'h5, 4'hF, 0, 1'b1, lat, eas);
        check("t4_words_consumed", hs_cnt - h0, 3);
        check("t4_latency", lat, 24);
        check("t4_done_pulses", done_cnt - d0, 1);
        check("t4_chain", chain, EXP_CHAIN);

        // Reset wins over a coincident start.
        reset = 1'b1; start = 1'b1;
        cyc();
        reset = 1'b0; start = 1'b0;
        check("start_with_reset_busy", busy, 1'b0);
        cyc();
        check("start_with_reset_idle", {busy, cfg_ready}, 2'b00);

        // Reset in the 6th SHIFT cycle.
        d0 = done_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        cfg_valid = 1'b1; cfg_data = 4'hA;
        n_en = 0;
        for (int t = 0; t < 50 && n_en < 5; t++) begin
            cyc();
            if (ccff_en) n_en++;
        end
        cyc();
        check("t5_sixth_shift", {ccff_en, bit_count}, {1'b1, CW'(5)});
        reset = 1'b1;
        cyc();
        reset = 1'b0; cfg_valid = 1'b0;
        check("t5_reset_outputs", {cfg_ready, ccff_en, ccff_head, busy, done, error, bit_count}, '0);
        repeat (30) cyc();
        check("t5_no_done", done_cnt - d0, 0);

        // Full load afterwards recovers the chain.
        run_load(4'hA, 4'h5, 4'hF, 0, 1'b0, lat, eas);
        check("t6_latency", lat, 24);
        check("t6_chain", chain, EXP_CHAIN);
        check("t6_error", error, 1'b0);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
